serial_latch_loader: RTL
========================

Name: serial_latch_loader

Overview:
- Upstream stage for the transparent D-latch bank.
- Deserialises a framed, MSB-first serial stream into a WIDTH-bit word.
- Drives the latch bank's `d` bus and a gated `enable` window.
- Guarantees `d` is stable for the whole time `enable` is high, so the asynchronous latch only ever captures a complete, validated word.

Parameters:
- WIDTH, 8: bits per frame, and the width of the latch bank; legal range 2..32.
- EN_CYCLES, 2: number of clk cycles `latch_en` stays high per load; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle strobe that begins a new frame.
- sdi  input  1  serial data bit, sampled only when sdi_valid=1.
- sdi_valid  input  1  qualifies sdi.
- latch_d  output  WIDTH  word presented to the latch bank's `d`.
- latch_en  output  1  latch-bank `enable`; high for exactly EN_CYCLES cycles per completed frame.
- busy  output  1  high in the SHIFT and LOAD states.
- frame_err  output  1  one-cycle pulse when the current frame is aborted.
- frame_count  output  8  number of completed loads, modulo 256.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - latch_d=0, latch_en=0, busy=0, frame_err=0, frame_count=0.
  - The shift register and bit counter are cleared.
  - Reset overrides every other input in the same cycle.
  - Reset asserted during LOAD drops latch_en on the next edge; the latch then holds whatever it captured, which is acceptable.
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - frame_start=1 goes to SHIFT, clears the bit counter and clears the shift register.
  - sdi_valid while IDLE is ignored.
- SHIFT:
  - Each cycle with sdi_valid=1 shifts the register left, inserts sdi at the LSB, and increments the bit counter.
  - Cycles with sdi_valid=0 hold all state; there is no timeout.
  - When the WIDTH-th valid bit is accepted, the next state is LOAD.
  - On that same edge, latch_d takes the full assembled word. It is registered, so latch_d changes exactly one cycle before latch_en rises.
- LOAD:
  - latch_en=1 for EN_CYCLES consecutive cycles, counted by an internal load counter.
  - latch_d is frozen throughout LOAD.
  - After the last enable cycle, the state returns to IDLE, latch_en falls, and frame_count increments (wraps 255 to 0).
  - frame_start and sdi_valid are ignored during LOAD, so no overlap is possible.
- Abort rule: frame_start=1 while in SHIFT restarts the frame.
  - Counter and register are cleared; the state stays SHIFT.
  - frame_err pulses for one cycle.
  - latch_d and frame_count are unchanged.
- Simultaneous frame_start and sdi_valid:
  - In IDLE, frame_start wins and that bit is discarded.
  - In SHIFT, the abort wins and the bit is discarded.
- latch_d is never updated outside the SHIFT-to-LOAD transition. Between frames it keeps the last loaded word, which matches the latch contents.
- latch_en is a registered output and is glitch-free.
- Latency:
  - From frame_start to latch_en rising = 1 + (number of cycles until the WIDTH-th valid bit) + 1.
  - With back-to-back valid bits, latch_en rises WIDTH+1 cycles after the frame_start edge.
- Bit counter width is clog2(WIDTH+1). Load counter width is 4 bits.
- busy = (state != IDLE).

Decomposition:
- Shared package `latch_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2);
  - default WIDTH and EN_CYCLES constants;
  - the FRAME_CNT_W=8 constant.
- One natural sub-module: `sipo_shreg`, a WIDTH-bit serial-in/parallel-out register with clear and shift-enable inputs.
- The FSM, counters and output registers stay in the top.

Test Plan:
- Reset applied mid-SHIFT after 3 bits, then released:
  - Required: all outputs 0, busy=0.
  - Required: the next full frame loads correctly with no residue from the aborted bits.
- WIDTH=8, EN_CYCLES=2; frame_start, then bits 1,0,1,0,0,1,0,1 back-to-back:
  - Required: latch_d=8'hA5 one cycle before latch_en.
  - Required: latch_en high for exactly 2 cycles, first high at cycle 9 after frame_start.
  - Required: frame_count 0 to 1; a behavioural latch model then shows q=8'hA5.
- Same frame with sdi_valid deasserted for 5 cycles after bit 4:
  - Required: latch_d=8'hA5; latch_en delayed by exactly 5 cycles.
  - Required: latch_d stays 0 during the gap.
- frame_start after 4 bits, then a full frame of 8'h3C:
  - Required: frame_err pulses for 1 cycle; latch_d stays at its old value until 8'h3C loads.
  - Required: exactly one latch_en window; frame_count increments by 1.
- frame_start and sdi_valid pulsed during LOAD:
  - Required: both ignored; latch_d frozen; latch_en width unchanged.
  - Required: state returns to IDLE.
- 256 consecutive frames:
  - Required: frame_count wraps to 0.
  - Required: latch_en never high while latch_d changes (checked by an assertion over the whole run).

Source files
------------

// File: rtl/latch_pkg.sv
// Shared constants for the serial latch loader: FSM encoding, defaults and
// counter widths.
package latch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_EN_CYCLES = 2;
  localparam int FRAME_CNT_W   = 8;
  localparam int LOAD_CNT_W    = 4;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit serial-in/parallel-out shift register, MSB first, with
// synchronous clear. Exposes its next value so the word can be captured
// on the same edge as the final shift.
module sipo_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q;

  always_comb begin
    q_next = q;
    if (clear) begin
      q_next = '0;
    end else if (shift_en) begin
      q_next = {q[WIDTH-2:0], sdi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/serial_latch_loader.sv
// Deserialises a framed MSB-first stream and drives a transparent latch bank
// with a registered word and an enable window during which the word is frozen.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for frame_start; latch_d holds the last loaded word
//   ST_SHIFT | collecting WIDTH valid bits; frame_start restarts the frame
//   ST_LOAD  | latch_d frozen; latch_en high for EN_CYCLES cycles
module serial_latch_loader
  import latch_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EN_CYCLES = DEF_EN_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   sdi,
  input  logic                   sdi_valid,
  output logic [WIDTH-1:0]       latch_d,
  output logic                   latch_en,
  output logic                   busy,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int BCW = bit_cnt_w(WIDTH);
  localparam logic [BCW-1:0]        LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [LOAD_CNT_W-1:0] EN_LOAD  = LOAD_CNT_W'(EN_CYCLES);

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [LOAD_CNT_W-1:0] load_cnt;
  logic [WIDTH-1:0]      word_next;
  logic                  restart;
  logic                  accept;

  // A start strobe clears the register in IDLE and aborts in SHIFT; in both
  // cases any coincident data bit is discarded.
  assign restart = frame_start && ((state == ST_IDLE) || (state == ST_SHIFT));
  assign accept  = (state == ST_SHIFT) && sdi_valid && !frame_start;
  assign busy    = (state != ST_IDLE);

  sipo_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .shift_en(accept),
    .sdi     (sdi),
    .q_next  (word_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      load_cnt    <= '0;
      latch_d     <= '0;
      latch_en    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (frame_start) begin
            bit_cnt   <= '0;
            frame_err <= 1'b1;
          end else if (sdi_valid) begin
            if (bit_cnt == LAST_BIT) begin
              // word_next already contains this final bit
              state    <= ST_LOAD;
              bit_cnt  <= '0;
              latch_d  <= word_next;
              load_cnt <= EN_LOAD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // First LOAD cycle only raises enable, giving d a full cycle of setup
          if (load_cnt == '0) begin
            state       <= ST_IDLE;
            latch_en    <= 1'b0;
            frame_count <= frame_count + 1'b1;
          end else begin
            latch_en <= 1'b1;
            load_cnt <= load_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          latch_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
